sdram_readback: RTL and testbench

SDRAM_READBACK -- requirements
Module: sdram_readback

---
 rtl/sdram_readback.sv | 243 ++++++++++++++++++++++++
 tb/tb_sdram_readback.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_readback.sv
// Generic first-word-fall-through FIFO used by the read-back engine.
// Latency: a written word is visible on rd_dat the cycle after the write.
// Backpressure: rd_vld holds with stable rd_dat until rd_rdy; the writer must respect count.
module fifo #(
    parameter int W  = 256,
    parameter int AW = 5
) (
    input  logic          sdram_clk,
    input  logic          sdram_rst,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Storage write; contents need no reset because the pointers qualify them.
    always_ff @(posedge sdram_clk) begin
        if (wr_vld && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    // Pointer update; a flush drops everything currently held.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_vld && rd_rdy) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign rd_vld = (wr_ptr != rd_ptr);
    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign count  = wr_ptr - rd_ptr;
endmodule

// Reads rd_count words from an SDRAM address ring over Avalon-MM bursts and streams them out.
// Latency: first command two cycles after launch; data leaves one cycle after its readdatavalid beat.
// Backpressure: out_ready stalls the stream; bursts wait until FIFO credit covers the whole burst.
module sdram_readback #(
    parameter int MAX_BURST = 8,
    parameter int FIFO_AW   = 5
) (
    input  logic          sdram_clk,
    input  logic          sdram_rst,
    input  logic          rd_launch,
    input  logic          rd_abort,
    input  logic [26:0]   rd_first_addr,
    input  logic [27:0]   rd_count,
    input  logic [26:0]   rd_addr_start,
    input  logic [26:0]   rd_addr_end,
    output logic          rd_busy,
    output logic          rd_done,
    output logic          rd_aborted,
    output logic [26:0]   sdram_address,
    output logic [7:0]    sdram_burstcount,
    output logic          sdram_read,
    input  logic          sdram_waitrequest,
    input  logic [255:0]  sdram_readdata,
    input  logic          sdram_readdatavalid,
    output logic          sdram_write,
    output logic [31:0]   sdram_byteenable,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [255:0]  out_data,
    output logic          out_last
);
    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [27:0]     MAX_LEN = 28'(MAX_BURST);
    localparam logic [27:0]     DEPTH_W = 28'(DEPTH);
    localparam logic [FIFO_AW:0] OUT_ONE = (FIFO_AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [26:0]       addr;
    logic [27:0]       remain;
    logic [27:0]       left_out;
    logic [FIFO_AW:0]  outstanding;
    logic              abort_pend;

    logic [FIFO_AW:0]  fifo_count;
    logic              fifo_vld;
    logic              fifo_wr;
    logic              fifo_pop;
    logic              fifo_flush;

    logic [27:0]       ring_left;
    logic [27:0]       want_len;
    logic [27:0]       credits;
    logic [27:0]       addr_sum;
    logic [26:0]       addr_next;
    logic [FIFO_AW:0]  out_add;
    logic [FIFO_AW:0]  out_sub;
    logic              accept;
    logic              abort_seen;
    logic              can_issue;
    logic              last_pop;
    logic              beat;

    assign sdram_write      = 1'b0;
    assign sdram_byteenable = '1;
    assign rd_busy          = (state != IDLE);

    assign accept     = sdram_read && !sdram_waitrequest;
    assign abort_seen = rd_abort || abort_pend;
    // Beats count against outstanding in ISSUE and FLUSH; in IDLE they are strays from a reset run.
    assign beat       = sdram_readdatavalid && (state != IDLE);
    assign fifo_wr    = sdram_readdatavalid && (state == ISSUE);
    assign fifo_flush = (state == FLUSH);
    assign out_valid  = fifo_vld && (state == ISSUE);
    assign fifo_pop   = out_valid && out_ready;
    assign out_last   = out_valid && (left_out == 28'd1);
    assign last_pop   = fifo_pop && (left_out == 28'd1);

    // Next burst length, FIFO credit and the ring-wrapped address after an accepted burst.
    always_comb begin
        ring_left = {1'b0, rd_addr_end} - {1'b0, addr} + 28'd1;
        want_len  = MAX_LEN;
        if (remain < want_len) begin
            want_len = remain;
        end
        if (ring_left < want_len) begin
            want_len = ring_left;
        end
        credits   = DEPTH_W - 28'(fifo_count) - 28'(outstanding);
        // Only full-length bursts go out: a short credit delays the burst rather than trimming it.
        can_issue = (state == ISSUE) && !sdram_read && !abort_seen &&
                    (remain != 28'd0) && (want_len <= credits);
        addr_sum  = {1'b0, addr} + {20'd0, sdram_burstcount};
        addr_next = (addr_sum > {1'b0, rd_addr_end}) ? rd_addr_start : addr_sum[26:0];
        out_add   = accept ? (FIFO_AW+1)'(sdram_burstcount) : '0;
        out_sub   = beat ? OUT_ONE : '0;
    end

    fifo #(
        .W  (256),
        .AW (FIFO_AW)
    ) u_fifo (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .flush     (fifo_flush),
        .wr_vld    (fifo_wr),
        .wr_dat    (sdram_readdata),
        .rd_vld    (fifo_vld),
        .rd_rdy    (fifo_pop),
        .rd_dat    (out_data),
        .count     (fifo_count)
    );

    // Run control: command issue, word accounting, abort flush and completion flags.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state            <= IDLE;
            addr             <= '0;
            remain           <= '0;
            left_out         <= '0;
            outstanding      <= '0;
            abort_pend       <= 1'b0;
            sdram_read       <= 1'b0;
            sdram_address    <= '0;
            sdram_burstcount <= '0;
            rd_done          <= 1'b0;
            rd_aborted       <= 1'b0;
        end else begin
            rd_done     <= 1'b0;
            outstanding <= outstanding + out_add - out_sub;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (rd_launch) begin
                        rd_aborted <= 1'b0;
                        if (rd_count == 28'd0) begin
                            rd_done <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            addr     <= rd_first_addr;
                            remain   <= rd_count;
                            left_out <= rd_count;
                        end
                    end
                end
                ISSUE: begin
                    // One idle cycle follows each accepted burst so credit is recomputed cleanly.
                    if (accept) begin
                        sdram_read <= 1'b0;
                        remain     <= remain - 28'(sdram_burstcount);
                        addr       <= addr_next;
                    end else if (can_issue) begin
                        sdram_read       <= 1'b1;
                        sdram_address    <= addr;
                        sdram_burstcount <= 8'(want_len);
                    end
                    if (fifo_pop) begin
                        left_out <= left_out - 28'd1;
                    end
                    if (last_pop) begin
                        state   <= IDLE;
                        rd_done <= 1'b1;
                    end else if (abort_seen) begin
                        // A stalled command is never retracted; leave once it is accepted.
                        if (sdram_read && !accept) begin
                            abort_pend <= 1'b1;
                        end else begin
                            state      <= FLUSH;
                            abort_pend <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (outstanding == '0) begin
                        state      <= IDLE;
                        rd_done    <= 1'b1;
                        rd_aborted <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_readback.sv
module tb_sdram_readback;
    logic          sdram_clk = 1'b0;
    logic          sdram_rst = 1'b1;
    logic          rd_launch = 1'b0;
    logic          rd_abort = 1'b0;
    logic [26:0]   rd_first_addr = '0;
    logic [27:0]   rd_count = '0;
    logic [26:0]   rd_addr_start = '0;
    logic [26:0]   rd_addr_end = '0;
    logic          rd_busy;
    logic          rd_done;
    logic          rd_aborted;
    logic [26:0]   sdram_address;
    logic [7:0]    sdram_burstcount;
    logic          sdram_read;
    logic          sdram_waitrequest = 1'b0;
    logic [255:0]  sdram_readdata = '0;
    logic          sdram_readdatavalid = 1'b0;
    logic          sdram_write;
    logic [31:0]   sdram_byteenable;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [255:0]  out_data;
    logic          out_last;

    sdram_readback #(.MAX_BURST(8), .FIFO_AW(5)) dut (
        .sdram_clk           (sdram_clk),
        .sdram_rst           (sdram_rst),
        .rd_launch           (rd_launch),
        .rd_abort            (rd_abort),
        .rd_first_addr       (rd_first_addr),
        .rd_count            (rd_count),
        .rd_addr_start       (rd_addr_start),
        .rd_addr_end         (rd_addr_end),
        .rd_busy             (rd_busy),
        .rd_done             (rd_done),
        .rd_aborted          (rd_aborted),
        .sdram_address       (sdram_address),
        .sdram_burstcount    (sdram_burstcount),
        .sdram_read          (sdram_read),
        .sdram_waitrequest   (sdram_waitrequest),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .sdram_write         (sdram_write),
        .sdram_byteenable    (sdram_byteenable),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct packed {
        logic [26:0] a;
        logic [31:0] t;
    } beat_t;

    typedef struct packed {
        logic [26:0]       first;
        logic [27:0]       count;
        logic [26:0]       rs;
        logic [26:0]       re;
        logic [3:0]        wt;
        logic [2:0]        ncmd;
        logic [2:0][26:0]  ca;
        logic [2:0][7:0]   cb;
    } vec_t;

    beat_t         pend[$];
    logic [255:0]  got_data[$];
    logic          got_last[$];
    logic [26:0]   cmd_a[$];
    logic [7:0]    cmd_b[$];

    int cyc = 0;
    int seen_valid = 0;
    int hold_err = 0;
    int stab_err = 0;
    int last_cyc = 0;
    int done_cyc = 0;
    int wait_used = 0;
    int wait_total = 0;
    int lat = 3;
    int req_words = 0;
    int del_words = 0;
    int max_infl = 0;
    logic          hold_seen = 1'b0;
    logic [26:0]   hold_a = '0;
    logic [7:0]    hold_b = '0;
    logic          prev_stall = 1'b0;
    logic [255:0]  prev_data = '0;
    logic          prev_last = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    // Avalon slave model (word = address, fixed latency) and stream collector, on the falling edge.
    always @(negedge sdram_clk) begin
        cyc = cyc + 1;
        if (out_valid) seen_valid = seen_valid + 1;
        if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) hold_err = hold_err + 1;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && out_ready && !sdram_rst) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            del_words = del_words + 1;
            if (out_last) last_cyc = cyc;
        end
        if (rd_done) done_cyc = cyc;

        if (sdram_read && wait_used < wait_total) begin
            sdram_waitrequest = 1'b1;
            wait_used = wait_used + 1;
        end else begin
            sdram_waitrequest = 1'b0;
        end
        if (sdram_read) begin
            if (hold_seen && (sdram_address !== hold_a || sdram_burstcount !== hold_b)) stab_err = stab_err + 1;
            hold_seen = sdram_waitrequest;
            hold_a = sdram_address;
            hold_b = sdram_burstcount;
        end else begin
            hold_seen = 1'b0;
        end
        if (sdram_read && !sdram_waitrequest && !sdram_rst) begin
            cmd_a.push_back(sdram_address);
            cmd_b.push_back(sdram_burstcount);
            for (int i = 0; i < int'(sdram_burstcount); i++) begin
                pend.push_back('{a: sdram_address + 27'(i), t: 32'(cyc + lat)});
            end
            req_words = req_words + int'(sdram_burstcount);
        end
        if (req_words - del_words > max_infl) max_infl = req_words - del_words;

        if (pend.size() > 0 && pend[0].t <= 32'(cyc)) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata = 256'(pend[0].a);
            void'(pend.pop_front());
        end else begin
            sdram_readdatavalid = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (rd_busy && n < budget) begin
            tick();
            n++;
        end
        check(nm, rd_busy, 1'b0);
    endtask

    task automatic wait_cmds(input int base, input int want);
        int n;
        n = 0;
        while (cmd_a.size() - base < want && n < 100) begin
            tick();
            n++;
        end
        check("wait_cmds", cmd_a.size() - base, want);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_busy"}, rd_busy, 1'b0);
        check({p, "_done"}, rd_done, 1'b0);
        check({p, "_aborted"}, rd_aborted, 1'b0);
        check({p, "_read"}, sdram_read, 1'b0);
        check({p, "_address"}, sdram_address, 27'd0);
        check({p, "_burstcount"}, sdram_burstcount, 8'd0);
        check({p, "_out_valid"}, out_valid, 1'b0);
        check({p, "_out_last"}, out_last, 1'b0);
    endtask

    task automatic launch(input logic [26:0] first, input logic [27:0] count);
        rd_first_addr = first;
        rd_count = count;
        rd_launch = 1'b1;
        tick();
        rd_launch = 1'b0;
    endtask

    function automatic vec_t mk(input logic [26:0] first, input logic [27:0] count,
                                input logic [26:0] rs, input logic [26:0] re,
                                input int wt, input int ncmd,
                                input logic [26:0] a0, input logic [7:0] b0,
                                input logic [26:0] a1, input logic [7:0] b1,
                                input logic [26:0] a2, input logic [7:0] b2);
        vec_t v;
        v.first = first;
        v.count = count;
        v.rs = rs;
        v.re = re;
        v.wt = 4'(wt);
        v.ncmd = 3'(ncmd);
        v.ca[0] = a0; v.cb[0] = b0;
        v.ca[1] = a1; v.cb[1] = b1;
        v.ca[2] = a2; v.cb[2] = b2;
        return v;
    endfunction

    task automatic do_run(input vec_t v);
        int db, cb, se, nlast;
        logic [26:0] a;
        db = got_data.size();
        cb = cmd_a.size();
        se = stab_err;
        rd_addr_start = v.rs;
        rd_addr_end = v.re;
        out_ready = 1'b1;
        if (v.wt != 0) wait_total = wait_used + int'(v.wt);
        launch(v.first, v.count);
        wait_idle(3000, "run_idle");
        tick();
        tick();
        check("run_ncmd", cmd_a.size() - cb, int'(v.ncmd));
        for (int i = 0; i < int'(v.ncmd); i++) begin
            if (cb + i < cmd_a.size()) begin
                check("run_cmd_addr", cmd_a[cb + i], v.ca[i]);
                check("run_cmd_len", cmd_b[cb + i], v.cb[i]);
            end
        end
        check("run_nwords", got_data.size() - db, int'(v.count));
        a = v.first;
        nlast = 0;
        for (int i = 0; i < int'(v.count); i++) begin
            if (db + i < got_data.size()) begin
                check("run_data", got_data[db + i], 256'(a));
                if (got_last[db + i]) nlast++;
                if (i == int'(v.count) - 1) check("run_last_pos", got_last[db + i], 1'b1);
            end
            a = (a == v.re) ? v.rs : a + 27'd1;
        end
        check("run_last_count", nlast, 1);
        check("run_done_latency", done_cyc, last_cyc + 1);
        check("run_cmd_stable", stab_err - se, 0);
        if (v.wt != 0) check("run_wait_applied", wait_used, wait_total);
    endtask

    vec_t vecs [7];
    int   db0, cb0, rq0, sv0;

    initial begin
        vecs[0] = mk(27'h100, 28'd20, 27'h100, 27'h1FF, 0, 3, 27'h100, 8'd8, 27'h108, 8'd8, 27'h110, 8'd4);
        vecs[1] = mk(27'h1FC, 28'd10, 27'h100, 27'h1FF, 0, 2, 27'h1FC, 8'd4, 27'h100, 8'd6, 27'h0, 8'd0);
        vecs[2] = mk(27'h1FF, 28'd3,  27'h100, 27'h1FF, 0, 2, 27'h1FF, 8'd1, 27'h100, 8'd2, 27'h0, 8'd0);
        vecs[3] = mk(27'h011, 28'd7,  27'h010, 27'h012, 0, 3, 27'h011, 8'd2, 27'h010, 8'd3, 27'h010, 8'd2);
        vecs[4] = mk(27'h7FFFFFC, 28'd6, 27'h7FFFFF8, 27'h7FFFFFF, 0, 2,
                     27'h7FFFFFC, 8'd4, 27'h7FFFFF8, 8'd2, 27'h0, 8'd0);
        vecs[5] = mk(27'h020, 28'd8,  27'h000, 27'h3FF, 5, 1, 27'h020, 8'd8, 27'h0, 8'd0, 27'h0, 8'd0);
        vecs[6] = mk(27'h040, 28'd1,  27'h000, 27'h3FF, 0, 1, 27'h040, 8'd1, 27'h0, 8'd0, 27'h0, 8'd0);

        // Reset state.
        repeat (3) tick();
        check_reset_vals("reset");
        check("reset_write_tied", sdram_write, 1'b0);
        check("reset_byteenable_tied", sdram_byteenable, 32'hFFFF_FFFF);
        sdram_rst = 1'b0;
        tick();

        // Directed runs from the table.
        for (int k = 0; k < 7; k++) begin
            do_run(vecs[k]);
        end

        // Backpressure: stream stalled, credit must cap requests at the FIFO depth.
        rd_addr_start = 27'h0;
        rd_addr_end = 27'h3FF;
        out_ready = 1'b0;
        db0 = got_data.size();
        cb0 = cmd_a.size();
        rq0 = req_words;
        launch(27'h0, 28'd100);
        repeat (120) tick();
        check("bp_words_requested", req_words - rq0, 32);
        check("bp_cmds", cmd_a.size() - cb0, 4);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_head_data", out_data, 256'd0);
        check("bp_busy", rd_busy, 1'b1);
        out_ready = 1'b1;
        wait_idle(3000, "bp_idle");
        tick();
        tick();
        check("bp_nwords", got_data.size() - db0, 100);
        for (int i = 0; i < 100; i++) begin
            if (db0 + i < got_data.size()) begin
                check("bp_data", got_data[db0 + i], 256'(i));
                check("bp_last", got_last[db0 + i], (i == 99) ? 1'b1 : 1'b0);
            end
        end
        check("bp_hold_stable", hold_err, 0);
        check("bp_credit_bound", (max_infl <= 32) ? 1'b1 : 1'b0, 1'b1);

        // Abort with two bursts in flight.
        lat = 20;
        cb0 = cmd_a.size();
        sv0 = seen_valid;
        launch(27'h0, 28'd64);
        wait_cmds(cb0, 2);
        rd_abort = 1'b1;
        tick();
        rd_abort = 1'b0;
        check("abort_busy_flush", rd_busy, 1'b1);
        wait_idle(300, "abort_idle");
        check("abort_done", rd_done, 1'b1);
        check("abort_flag", rd_aborted, 1'b1);
        check("abort_beats_drained", pend.size(), 0);
        tick();
        check("abort_done_pulse", rd_done, 1'b0);
        repeat (5) tick();
        check("abort_no_new_cmds", cmd_a.size() - cb0, 2);
        check("abort_no_out_valid", seen_valid - sv0, 0);
        lat = 3;

        // Zero-length launch.
        cb0 = cmd_a.size();
        launch(27'h0, 28'd0);
        check("zero_done", rd_done, 1'b1);
        check("zero_busy", rd_busy, 1'b0);
        check("zero_aborted_cleared", rd_aborted, 1'b0);
        tick();
        check("zero_done_pulse", rd_done, 1'b0);
        repeat (5) tick();
        check("zero_no_cmd", cmd_a.size() - cb0, 0);
        check("zero_no_read", sdram_read, 1'b0);

        // Reset mid-run with beats still in flight.
        lat = 10;
        cb0 = cmd_a.size();
        launch(27'h0, 28'd64);
        wait_cmds(cb0, 2);
        sdram_rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick();
        tick();
        sdram_rst = 1'b0;
        sv0 = seen_valid;
        repeat (30) tick();
        check("midrst_stray_ignored", seen_valid - sv0, 0);
        check("midrst_idle", rd_busy, 1'b0);
        check("midrst_strays_sent", pend.size(), 0);
        lat = 3;
        do_run(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
